// File: rtl/ws2812_regen_multi_pkg.sv
// Shared types and parameter checks for the multi-channel WS2812 regenerator.
`timescale 1ns/1ps
package ws2812_regen_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUAL     = 2'd1,
        ST_HIGH     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } ch_state_t;

    typedef struct packed {
        int glitch;
        int t0h;
        int t1h_min;
        int t1h;
        int cnt_max;
        int treset;
        int rst_lim;
    } decode_params_t;

    // Timing must fit inside the saturating counters, and a 1 must take longer than a 0.
    function automatic bit params_ok(decode_params_t p);
        return (p.glitch >= 1) &&
               (p.t0h < p.t1h_min) &&
               (p.t1h_min <= p.t1h) &&
               (p.t1h < p.cnt_max) &&
               (p.treset < p.rst_lim);
    endfunction

endpackage

// File: rtl/ws2812_regen_multi_reshaper_channel.sv
// One WS2812 channel: qualifies input highs, classifies the bit and re-emits it with nominal timing.
`timescale 1ns/1ps
module reshaper_channel
    import ws2812_regen_multi_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int GLITCH_CYCLES  = 2,
    parameter int T0H_CYCLES     = 20,
    parameter int T1H_MIN_CYCLES = 30,
    parameter int T1H_CYCLES     = 40,
    parameter int RST_W          = 12,
    parameter int TRESET_CYCLES  = 2500
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic reshaped,
    output logic bit_valid,
    output logic bit_value,
    output logic frame_end,
    output logic stuck_set,
    output logic overlap_set
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] GLITCH_C   = CNT_W'(GLITCH_CYCLES);
    localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(T1H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_MIN_M1 = CNT_W'(T1H_MIN_CYCLES - 1);
    localparam logic [RST_W-1:0] LOW_MAX    = '1;
    localparam logic [RST_W-1:0] TRESET_M1  = RST_W'(TRESET_CYCLES - 1);

    ch_state_t        state_reg, state_next;
    logic [CNT_W-1:0] in_cnt_reg, in_cnt_next;
    logic [CNT_W-1:0] hi_cnt_reg, hi_cnt_next;
    logic [RST_W-1:0] low_cnt_reg, low_cnt_next;
    logic             decided_reg, decided_next;
    logic             bit_reg, bit_next;
    logic             fell_reg, fell_next;
    logic             in_prev_reg;
    logic             out_reg, out_next;
    logic             valid_reg, valid_next;
    logic             value_reg, value_next;
    logic             frame_reg, frame_next;
    logic             stuck_reg, stuck_next;
    logic             overlap_reg, overlap_next;

    logic [CNT_W-1:0] in_inc;
    logic [CNT_W-1:0] hi_inc;
    logic [CNT_W-1:0] fall_target;
    logic             fall;

    assign in_inc      = (in_cnt_reg == CNT_MAX) ? CNT_MAX : in_cnt_reg + 1'b1;
    assign hi_inc      = (hi_cnt_reg == CNT_MAX) ? CNT_MAX : hi_cnt_reg + 1'b1;
    assign fall_target = bit_reg ? T1H_C : T0H_C;

    // A decided bit ends at its nominal width; an undecided long 0 ends as soon as the input drops.
    assign fall = (state_reg == ST_HIGH) &&
                  ((decided_reg && (hi_cnt_reg == fall_target)) ||
                   (!decided_reg && !sig && (hi_cnt_reg >= T0H_C)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sig) state_next = ST_QUAL;
            end
            ST_QUAL: begin
                if (!sig) state_next = ST_IDLE;
                else if (in_cnt_reg == GLITCH_C) state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (fall) state_next = sig ? ST_WAIT_LOW : ST_IDLE;
            end
            ST_WAIT_LOW: begin
                if (!sig) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_cnt_next  = in_cnt_reg;
        hi_cnt_next  = hi_cnt_reg;
        low_cnt_next = '0;
        decided_next = decided_reg;
        bit_next     = bit_reg;
        fell_next    = fell_reg;
        out_next     = 1'b0;
        valid_next   = 1'b0;
        value_next   = 1'b0;
        frame_next   = 1'b0;
        stuck_next   = 1'b0;
        overlap_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sig) begin
                    in_cnt_next = CNT_ONE;
                end else begin
                    low_cnt_next = (low_cnt_reg == LOW_MAX) ? LOW_MAX : low_cnt_reg + 1'b1;
                    frame_next   = (low_cnt_reg == TRESET_M1);
                end
            end
            ST_QUAL: begin
                if (sig) begin
                    in_cnt_next = in_inc;
                    if (in_cnt_reg == GLITCH_C) begin
                        out_next     = 1'b1;
                        hi_cnt_next  = CNT_ONE;
                        decided_next = 1'b0;
                        bit_next     = 1'b0;
                        fell_next    = 1'b0;
                    end
                end
            end
            ST_HIGH: begin
                out_next    = !fall;
                hi_cnt_next = hi_inc;
                if (sig) begin
                    // A new rise after the input already fell is a second pulse; it is dropped.
                    if (fell_reg && !in_prev_reg) begin
                        in_cnt_next  = CNT_ONE;
                        overlap_next = 1'b1;
                    end else begin
                        in_cnt_next = in_inc;
                        stuck_next  = (in_cnt_reg == CNT_MAX_M1);
                    end
                    if (!decided_reg && (in_cnt_reg == T1H_MIN_M1)) begin
                        valid_next   = 1'b1;
                        value_next   = 1'b1;
                        decided_next = 1'b1;
                        bit_next     = 1'b1;
                    end
                end else begin
                    fell_next = 1'b1;
                    if (!decided_reg) begin
                        valid_next   = 1'b1;
                        value_next   = 1'b0;
                        decided_next = 1'b1;
                        bit_next     = 1'b0;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (sig) begin
                    in_cnt_next = in_inc;
                    stuck_next  = (in_cnt_reg == CNT_MAX_M1);
                end
            end
            default: begin
                in_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt_reg  <= '0;
            hi_cnt_reg  <= '0;
            low_cnt_reg <= '0;
            decided_reg <= 1'b0;
            bit_reg     <= 1'b0;
            fell_reg    <= 1'b0;
            in_prev_reg <= 1'b0;
            out_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            value_reg   <= 1'b0;
            frame_reg   <= 1'b0;
            stuck_reg   <= 1'b0;
            overlap_reg <= 1'b0;
        end else begin
            in_cnt_reg  <= in_cnt_next;
            hi_cnt_reg  <= hi_cnt_next;
            low_cnt_reg <= low_cnt_next;
            decided_reg <= decided_next;
            bit_reg     <= bit_next;
            fell_reg    <= fell_next;
            in_prev_reg <= sig;
            out_reg     <= out_next;
            valid_reg   <= valid_next;
            value_reg   <= value_next;
            frame_reg   <= frame_next;
            stuck_reg   <= stuck_next;
            overlap_reg <= overlap_next;
        end
    end

    assign reshaped    = out_reg;
    assign bit_valid   = valid_reg;
    assign bit_value   = value_reg;
    assign frame_end   = frame_reg;
    assign stuck_set   = stuck_reg;
    assign overlap_set = overlap_reg;

endmodule

// File: rtl/ws2812_regen_multi.sv
// Multi-channel WS2812 regenerator: independent channel reshapers plus sticky error flags.
`timescale 1ns/1ps
module ws2812_regen_multi
    import ws2812_regen_multi_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 8,
    parameter int GLITCH_CYCLES  = 2,
    parameter int T0H_CYCLES     = 20,
    parameter int T1H_MIN_CYCLES = 30,
    parameter int T1H_CYCLES     = 40,
    parameter int RST_W          = 12,
    parameter int TRESET_CYCLES  = 2500
)
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NUM_CH-1:0] i_signal_synced,
    output logic [NUM_CH-1:0] o_reshaped_signal,
    output logic [NUM_CH-1:0] o_bit_valid,
    output logic [NUM_CH-1:0] o_bit_value,
    output logic [NUM_CH-1:0] o_frame_end,
    output logic [NUM_CH-1:0] o_err_stuck,
    output logic [NUM_CH-1:0] o_err_overlap,
    input  logic              i_err_clr
);

    localparam decode_params_t DECODE = '{
        glitch:  GLITCH_CYCLES,
        t0h:     T0H_CYCLES,
        t1h_min: T1H_MIN_CYCLES,
        t1h:     T1H_CYCLES,
        cnt_max: (2 ** CNT_W) - 1,
        treset:  TRESET_CYCLES,
        rst_lim: 2 ** RST_W
    };

    if (!params_ok(DECODE)) begin : g_param_err
        $error("ws2812_regen_multi: inconsistent timing parameters");
    end

    logic [NUM_CH-1:0] stuck_set;
    logic [NUM_CH-1:0] overlap_set;
    logic [NUM_CH-1:0] err_stuck_reg;
    logic [NUM_CH-1:0] err_overlap_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        reshaper_channel #(
            .CNT_W          (CNT_W),
            .GLITCH_CYCLES  (GLITCH_CYCLES),
            .T0H_CYCLES     (T0H_CYCLES),
            .T1H_MIN_CYCLES (T1H_MIN_CYCLES),
            .T1H_CYCLES     (T1H_CYCLES),
            .RST_W          (RST_W),
            .TRESET_CYCLES  (TRESET_CYCLES)
        ) u_ch (
            .clk         (i_clk),
            .rst_n       (i_reset_n),
            .sig         (i_signal_synced[gi]),
            .reshaped    (o_reshaped_signal[gi]),
            .bit_valid   (o_bit_valid[gi]),
            .bit_value   (o_bit_value[gi]),
            .frame_end   (o_frame_end[gi]),
            .stuck_set   (stuck_set[gi]),
            .overlap_set (overlap_set[gi])
        );
    end

    // A set arriving in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            err_stuck_reg   <= '0;
            err_overlap_reg <= '0;
        end else begin
            err_stuck_reg   <= (err_stuck_reg   & ~{NUM_CH{i_err_clr}}) | stuck_set;
            err_overlap_reg <= (err_overlap_reg & ~{NUM_CH{i_err_clr}}) | overlap_set;
        end
    end

    assign o_err_stuck   = err_stuck_reg;
    assign o_err_overlap = err_overlap_reg;

endmodule

// File: tb/tb_ws2812_regen_multi.sv
// Scoreboard bench for ws2812_regen_multi: directed pulses, queued expectations, negedge monitor.
`timescale 1ns/1ps
module tb_ws2812_regen_multi;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] sig;
    logic [NUM_CH-1:0] reshaped, bit_valid, bit_value, frame_end, err_stuck, err_overlap;
    logic              err_clr;

    always #5 clk = ~clk;

    ws2812_regen_multi #(
        .NUM_CH(4), .CNT_W(8), .GLITCH_CYCLES(2), .T0H_CYCLES(20),
        .T1H_MIN_CYCLES(30), .T1H_CYCLES(40), .RST_W(12), .TRESET_CYCLES(2500)
    ) dut (
        .i_clk             (clk),
        .i_reset_n         (reset_n),
        .i_signal_synced   (sig),
        .o_reshaped_signal (reshaped),
        .o_bit_valid       (bit_valid),
        .o_bit_value       (bit_value),
        .o_frame_end       (frame_end),
        .o_err_stuck       (err_stuck),
        .o_err_overlap     (err_overlap),
        .i_err_clr         (err_clr)
    );

    typedef struct { int cyc; int val; } bit_exp_t;
    typedef struct { int rise; int width; } pulse_exp_t;

    bit_exp_t   bit_q[NUM_CH][$];
    pulse_exp_t pulse_q[NUM_CH][$];
    int         rise_at[NUM_CH];
    int         fe_cnt[NUM_CH];
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT reports a bit or finishes an output pulse.
    initial begin
        logic [NUM_CH-1:0] prev_out;
        bit_exp_t          be;
        pulse_exp_t        pe;
        int                width;
        prev_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fe_cnt[c]  = 0;
            rise_at[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (frame_end[c] === 1'b1) fe_cnt[c]++;
                if (mon_en) begin
                    if (bit_valid[c] === 1'b1) begin
                        compared++;
                        if (bit_q[c].size() == 0) begin
                            mismatched++;
                            $display("FAIL bit ch%0d: got value %0b at cycle %0d, required no bit", c, bit_value[c], cyc);
                        end else begin
                            be = bit_q[c].pop_front();
                            if (bit_value[c] !== be.val[0] || cyc != be.cyc) begin
                                mismatched++;
                                $display("FAIL bit ch%0d: got value %0b at cycle %0d, required %0d at cycle %0d",
                                         c, bit_value[c], cyc, be.val, be.cyc);
                            end
                        end
                    end
                    if (reshaped[c] === 1'b1 && !prev_out[c]) rise_at[c] = cyc;
                    if (reshaped[c] !== 1'b1 && prev_out[c]) begin
                        width = cyc - rise_at[c];
                        compared++;
                        if (pulse_q[c].size() == 0) begin
                            mismatched++;
                            $display("FAIL pulse ch%0d: got rise %0d width %0d, required no pulse", c, rise_at[c], width);
                        end else begin
                            pe = pulse_q[c].pop_front();
                            if (rise_at[c] != pe.rise || width != pe.width) begin
                                mismatched++;
                                $display("FAIL pulse ch%0d: got rise %0d width %0d, required rise %0d width %0d",
                                         c, rise_at[c], width, pe.rise, pe.width);
                            end
                        end
                    end
                end
                prev_out[c] = (reshaped[c] === 1'b1);
            end
        end
    end

    // One input pulse; ev<0 means no output is expected. dec/width are hand-computed offsets.
    task automatic pulse(input int ch, input int hi, input int lo, input int ev, input int dec, input int width);
        int         t0;
        bit_exp_t   be;
        pulse_exp_t pe;
        @(negedge clk);
        sig[ch] = 1'b1;
        t0 = cyc;
        if (ev >= 0) begin
            be.cyc = t0 + dec;  be.val = ev;
            pe.rise = t0 + 3;   pe.width = width;
            bit_q[ch].push_back(be);
            pulse_q[ch].push_back(pe);
        end
        repeat (hi) @(negedge clk);
        sig[ch] = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        int         t0;
        bit_exp_t   be;
        pulse_exp_t pe;
        reset_n = 1'b0;
        sig     = '0;
        err_clr = 1'b0;
        repeat (4) @(negedge clk);
        expect_eq("reset_out",     32'(reshaped),    32'h0);
        expect_eq("reset_valid",   32'(bit_valid),   32'h0);
        expect_eq("reset_frame",   32'(frame_end),   32'h0);
        expect_eq("reset_stuck",   32'(err_stuck),   32'h0);
        expect_eq("reset_overlap", 32'(err_overlap), 32'h0);
        reset_n = 1'b1;

        // Frame end: low gap of 2500 samples after reset, exactly one pulse per channel.
        repeat (2400) @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) expect_eq($sformatf("frame_early_ch%0d", c), 32'(fe_cnt[c]), 32'd0);
        repeat (200) @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) expect_eq($sformatf("frame_once_ch%0d", c), 32'(fe_cnt[c]), 32'd1);

        mon_en = 1'b1;
        pulse(0, 20, 50, 0, 21, 20);
        pulse(0, 42, 50, 1, 30, 40);
        pulse(0, 26, 50, 0, 27, 24);
        pulse(0, 22, 50, 0, 23, 20);
        pulse(0,  3, 50, 0,  4, 20);
        pulse(0, 30, 50, 1, 30, 40);
        pulse(0, 29, 50, 0, 30, 27);
        pulse(0,  2, 20, -1, 0, 0);
        pulse(0,  1, 20, -1, 0, 0);

        // Overlap: high 10, low 3, high 20 -> one 0 bit, second pulse dropped.
        @(negedge clk);
        sig[0] = 1'b1;
        t0 = cyc;
        be.cyc = t0 + 11; be.val = 0;  bit_q[0].push_back(be);
        pe.rise = t0 + 3; pe.width = 20; pulse_q[0].push_back(pe);
        repeat (10) @(negedge clk);
        sig[0] = 1'b0;
        repeat (3) @(negedge clk);
        sig[0] = 1'b1;
        repeat (20) @(negedge clk);
        sig[0] = 1'b0;
        repeat (50) @(negedge clk);
        expect_eq("overlap_set", 32'(err_overlap), 32'h1);
        expect_eq("stuck_clean", 32'(err_stuck),   32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        expect_eq("overlap_clr", 32'(err_overlap), 32'h0);

        // Independent channels driven simultaneously.
        fork
            pulse(1, 42, 50, 1, 30, 40);
            pulse(2, 20, 50, 0, 21, 20);
        join

        // Stuck high on channel 3.
        pulse(3, 300, 50, 1, 30, 40);
        expect_eq("stuck_set",     32'(err_stuck),   32'h8);
        expect_eq("overlap_quiet", 32'(err_overlap), 32'h0);

        repeat (2600) @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            expect_eq($sformatf("frame_second_ch%0d", c), 32'(fe_cnt[c]), 32'd2);
            expect_eq($sformatf("bits_left_ch%0d", c),    32'(bit_q[c].size()),   32'd0);
            expect_eq($sformatf("pulses_left_ch%0d", c),  32'(pulse_q[c].size()), 32'd0);
        end

        // Reset mid-pulse forces everything low on the next edge.
        mon_en = 1'b0;
        @(negedge clk);
        sig[0] = 1'b1;
        repeat (10) @(negedge clk);
        expect_eq("midpulse_high", 32'(reshaped), 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        expect_eq("rst_out",     32'(reshaped),    32'h0);
        expect_eq("rst_valid",   32'(bit_valid),   32'h0);
        expect_eq("rst_stuck",   32'(err_stuck),   32'h0);
        expect_eq("rst_overlap", 32'(err_overlap), 32'h0);
        sig[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_eq("post_rst_out", 32'(reshaped), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
